pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic inter-stage pipeline register. Generic replacement for the fixed-width IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Carries instruction, PC, a data payload and a control bundle, each of configurable width.
- Uses a valid/ready handshake with a 1-entry skid buffer, so back-pressure never drops a transfer and the ready path is registered.
- Supports flush with NOP/bubble injection, plus saturating stall and flush counters for performance debug.

Parameters:
- DATA_W, 96, payload width (e.g. rs1data, rs2data, imm packed).
- CTRL_W, 16, control bundle width (ALUSel, WBSel, MemRW, RegWEn, ...).
- PC_W, 32, PC width.
- NOP_INSTR, 32'h0000_0013, instruction word presented while the output is invalid.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all held and incoming entries.
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  stage can accept; registered.
- in_instr_i  in  32  instruction.
- in_pc_i  in  PC_W  PC.
- in_data_i  in  DATA_W  payload.
- in_ctrl_i  in  CTRL_W  control bundle.
- out_valid_o  out  1  downstream entry valid.
- out_ready_i  in  1  downstream accepts.
- out_instr_o  out  32  instruction, or NOP_INSTR when invalid.
- out_pc_o  out  PC_W  PC, or 0 when invalid.
- out_data_o  out  DATA_W  payload, or 0 when invalid.
- out_ctrl_o  out  CTRL_W  control, or 0 when invalid.
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0; saturating.
- flush_cnt_o  out  CNT_W  flushes that killed at least one valid entry; saturating.

Behaviour:
- Storage:
  - Main register M (drives the outputs) with valid bit m_v.
  - Skid register S with valid bit s_v.
  - in_ready_o = !s_v, taken directly from a flop.
- Output gating:
  - out_valid_o = m_v.
  - When m_v=0: out_instr_o = NOP_INSTR; pc, data and ctrl are 0. This guarantees RegWEn/MemRW are 0 for every bubble.
- Handshakes:
  - Input transfer: in_fire = in_valid_i & in_ready_o.
  - Output transfer: out_fire = m_v & out_ready_i.
- Next state when flush_i=0 and rst_i=0:
  - !m_v & in_fire: M<=in, m_v<=1.
  - m_v & out_fire & !s_v & in_fire: M<=in (pass-through, full throughput).
  - m_v & out_fire & !s_v & !in_fire: m_v<=0.
  - m_v & !out_fire & in_fire: S<=in, s_v<=1 (the skid absorbs the entry; in_ready_o drops next cycle).
  - m_v & out_fire & s_v: M<=S, s_v<=0. in_ready_o cannot be 1 in this cycle, so no input is taken.
  - Otherwise: hold.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid_o when the stage is empty.
  - Sustained throughput is 1 per cycle with out_ready_i=1.
  - Entry order is strictly preserved; S is always older than any new input.
- Flush:
  - Has priority over everything except reset.
  - On the next edge: m_v<=0, s_v<=0, in_ready_o<=1.
  - An input presented in the same cycle is discarded even if in_fire=1.
  - An output presented in the same cycle with out_ready_i=1 still counts as transferred downstream. Whether the consumer uses it is the consumer's choice.
  - flush_cnt increments when (m_v|s_v) is 1 at the flush edge.
- Reset:
  - Covers m_v, s_v, in_ready_o=1 and both counters = 0. Payload flops need no reset, because the outputs are gated.
  - Reset mid-operation drops all entries with no partial transfer.
  - rst_i overrides flush_i.
- Counters:
  - Saturate at 2^CNT_W-1 and do not wrap.
  - stall_cnt also counts during flush cycles if the stall condition holds.
- Combinational paths:
  - No combinational path from out_ready_i to in_ready_o.
  - No combinational path from in_valid_i to out_valid_o.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, then in_valid_i=0 -> out_valid_o=0, out_instr_o=32'h13, out_ctrl_o=0, in_ready_o=1, both counters 0.
- Streaming: out_ready_i=1, 4 back-to-back inputs with pc 0x0,0x4,0x8,0xC -> outputs appear 1 cycle later in order, one per cycle, in_ready_o stays 1, stall_cnt_o=0.
- Back-pressure:
  - Stimulus: out_ready_i=0 while 2 entries (pc 0x10, 0x14) are sent.
  - Response: in_ready_o=0 from the cycle after the second accept, third input is held off, stall_cnt_o increments each stalled cycle.
  - Release: out_ready_i=1 -> 0x10 then 0x14 emitted, in_ready_o returns to 1 one cycle after 0x10 leaves.
- Flush with full stage: M and S valid, flush_i=1 with in_valid_i=1 (pc 0x20) -> next cycle out_valid_o=0, outputs are NOP/0, in_ready_o=1, 0x20 never appears, flush_cnt_o=1.
- Flush of an empty stage: flush_i=1 with m_v=s_v=0 -> flush_cnt_o unchanged. Reset asserted together with flush_i and in_valid_i -> reset state, counters 0.
- Saturation: CNT_W=4, hold out_ready_i=0 with a valid entry for 20 cycles -> stall_cnt_o reaches 15 and stays at 15.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register with a 1-entry skid buffer, flush/bubble injection and perf counters.
// Latency: 1 cycle from input accept to output valid when empty; sustains 1 entry/cycle.
// Backpressure: ready is a flop (!skid_valid); a stalled output parks one extra entry in the skid, nothing is dropped.
//
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i
//   in_valid_i / in_ready_o / in_instr_i / in_pc_i / in_data_i / in_ctrl_i      upstream side
//   out_valid_o / out_ready_i / out_instr_o / out_pc_o / out_data_o / out_ctrl_o downstream side
//   stall_cnt_o, flush_cnt_o                                                    saturating perf counters
module pipe_stage_reg #(
  parameter int unsigned DATA_W    = 96,
  parameter int unsigned CTRL_W    = 16,
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       in_instr_i,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_instr_o,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef struct packed {
    logic [31:0]       instr;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ent_t             m_q, m_d;
  ent_t             s_q, s_d;
  ent_t             in_ent;
  logic             m_v_q, m_v_d;
  logic             s_v_q, s_v_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             in_fire;
  logic             out_fire;

  always_comb begin
    in_ent      = '{instr: in_instr_i, pc: in_pc_i, data: in_data_i, ctrl: in_ctrl_i};
    in_fire     = in_valid_i & in_ready_q;
    out_fire    = m_v_q & out_ready_i;

    m_d         = m_q;
    s_d         = s_q;
    m_v_d       = m_v_q;
    s_v_d       = s_v_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (flush_i) begin
      // Kill everything held and anything offered this cycle.
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (!m_v_q) begin
      // Skid is never valid while main is empty.
      if (in_fire) begin
        m_d   = in_ent;
        m_v_d = 1'b1;
      end
    end else if (out_fire) begin
      if (s_v_q) begin
        // Skid is older than anything upstream; ready was low so no input here.
        m_d   = s_q;
        s_v_d = 1'b0;
      end else if (in_fire) begin
        m_d   = in_ent;
      end else begin
        m_v_d = 1'b0;
      end
    end else if (in_fire) begin
      // Output stalled but ready was still high: park the entry in the skid.
      s_d   = in_ent;
      s_v_d = 1'b1;
    end

    // Ready is registered so there is no out_ready_i -> in_ready_o path.
    in_ready_d = ~s_v_d;

    if (m_v_q && !out_ready_i && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (flush_i && (m_v_q || s_v_q) && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_v_q       <= 1'b0;
      s_v_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      m_v_q       <= m_v_d;
      s_v_q       <= s_v_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Payload needs no reset: outputs are gated by the valid bit.
  always_ff @(posedge clk_i) begin
    m_q <= m_d;
    s_q <= s_d;
  end

  // Bubbles present a NOP with zeroed control so no write enables leak.
  assign out_valid_o = m_v_q;
  assign out_instr_o = m_v_q ? m_q.instr : NOP_INSTR;
  assign out_pc_o    = m_v_q ? m_q.pc    : '0;
  assign out_data_o  = m_v_q ? m_q.data  : '0;
  assign out_ctrl_o  = m_v_q ? m_q.ctrl  : '0;
  assign in_ready_o  = in_ready_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
